pulse_meas_ctrl: RTL and testbench
==================================

# pulse_meas_ctrl

Measurement sequencer for the AD9280 pulse-shaping path. On command it opens a fixed gate window, counts rising edges of the comparator output `ad_pulse`, and tracks min/max of the raw `ad_data` samples. At gate close it publishes the count and recomputes the comparator threshold `trig_level` as the signal midpoint. It sits between the AD front end and the frequency/readout logic and owns the comparator's threshold configuration.

## Interface
- `DATA_W`, 8: ADC sample width.
- `CNT_W`, 32: edge counter / result width.
- `GATE_CYCLES`, 50_000_000: gate length in `ad_clk` cycles (≥ 1).
- `TRIG_INIT`, 8'd128: `trig_level` after reset.
- `MIN_SWING`, 8: minimum (max − min) for a threshold update.

- `ad_clk` in 1: AD9280 sample clock; only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: measurement request; sampled every cycle.
- `ad_data` in DATA_W: raw ADC sample.
- `ad_pulse` in 1: comparator output.
- `trig_level` out DATA_W: threshold to comparator; reset TRIG_INIT.
- `busy` out 1: high outside IDLE; reset 0.
- `done` out 1: one-cycle result strobe; reset 0.
- `edge_cnt` out CNT_W: rising edges in last gate; reset 0.
- `data_max` / `data_min` out DATA_W: extremes in last gate; reset 0 / 0.
- `no_signal` out 1: last gate swing < MIN_SWING; reset 0.

## Operation
- States: IDLE, GATE, UPDATE.
- IDLE: `start`=1 → GATE; clear gate counter and edge accumulator, min accumulator ← all-ones, max accumulator ← 0.
- GATE: each cycle samples `ad_data` into min/max, adds one on each rising edge, and increments the gate counter. After GATE_CYCLES cycles → UPDATE.
- Rising edge is `ad_pulse & ~pulse_q`. `pulse_q` is registered in every state, so a pulse already high at gate entry is not counted. An edge in the first GATE cycle counts only if `pulse_q` was 0 the cycle before.
- Edge accumulator saturates at all-ones and does not wrap.
- UPDATE (1 cycle): compute swing = max − min (unsigned; max ≥ min is guaranteed since GATE_CYCLES ≥ 1).
  - If swing ≥ MIN_SWING: `trig_level` ← (max + min) >> 1, using a DATA_W+1-bit sum with truncation, and `no_signal` ← 0.
  - Otherwise `trig_level` holds and `no_signal` ← 1.
  - `edge_cnt`, `data_max`, `data_min` ← accumulators.
  - → IDLE.
- `start` outside IDLE is ignored and not queued. `start` held high restarts immediately from IDLE.
- Result outputs hold until the next UPDATE.
- `rst_n`=0 at any point, mid-gate included: state → IDLE, accumulators cleared, all outputs to reset values, partial results discarded.

## Timing
- `start` high at edge t → GATE for cycles t+1 … t+GATE_CYCLES.
- UPDATE at t+GATE_CYCLES+1. `done`, results and `trig_level` change on that same edge and are visible in cycle t+GATE_CYCLES+2.
- Start-to-done latency is GATE_CYCLES+2 cycles. The earliest back-to-back `start` is accepted the cycle `done` is high (state is IDLE then).
- `busy` is high from t+1 through the UPDATE cycle.
- `trig_level` changes only in the cycle after UPDATE. The comparator therefore sees a constant threshold for the whole gate.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `pulse_pkg`: state enum (IDLE/GATE/UPDATE), `DATA_W` default, `TRIG_INIT` default. The comparator uses the same threshold default from here.
- Sub-module `pulse_edge_cnt` holds `pulse_q`, edge detect, and the saturating CNT_W counter with clear/enable. The top holds the FSM, gate counter, min/max and threshold arithmetic.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `trig_level`=128, `busy`=`done`=`no_signal`=0, `edge_cnt`=0.
- GATE_CYCLES=100, `ad_pulse` square with period 10 (high 5), low at start → `done` at start+102, `edge_cnt`=10, `busy` high for exactly 101 cycles.
- `ad_data` ramp 40→200 during gate → `data_min`=40, `data_max`=200, `trig_level`=120, `no_signal`=0. A second gate with 0/255 → `trig_level`=127.
- `ad_data` constant 100 → `no_signal`=1, `trig_level` unchanged, `data_min`=`data_max`=100.
- `start` pulsed mid-gate → no effect, single `done`. `rst_n` low at gate cycle 50 → IDLE, no `done`, outputs at reset values.
- CNT_W=4, 30 edges in gate → `edge_cnt`=15 (saturated).

Source files
------------

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared FSM states and defaults for the pulse measurement path,
// also used by the comparator for its threshold default.
package pulse_pkg;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] TRIG_INIT_DEF = 8'd128;
  typedef enum logic [1:0] {IDLE, GATE, UPDATE} state_t;
endpackage

// File: rtl/pulse_edge_cnt.sv
// pulse_edge_cnt: rising-edge detector with a saturating counter.
module pulse_edge_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  logic pulse_q;
  // pulse_q tracks every cycle, so a level already high at gate entry is not an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      cnt <= '0;
    end else begin
      pulse_q <= pulse;
      cnt <= clr ? '0 : (en && pulse && !pulse_q && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/pulse_meas_ctrl.sv
// pulse_meas_ctrl: gated edge count and min/max tracking, recomputes the
// comparator threshold as the signal midpoint at gate close.
module pulse_meas_ctrl
  import pulse_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = 32,
  parameter int GATE_CYCLES = 50_000_000,
  parameter logic [DATA_W-1:0] TRIG_INIT = DATA_W'(TRIG_INIT_DEF),
  parameter int MIN_SWING = 8
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_pulse,
  output logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  edge_cnt,
  output logic [DATA_W-1:0] data_max,
  output logic [DATA_W-1:0] data_min,
  output logic              no_signal
);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  state_t state;
  logic [GW-1:0] gate_cnt;
  logic [DATA_W-1:0] mn, mx, swing;
  logic [DATA_W:0] sum;
  logic [CNT_W-1:0] acc;
  assign sum = {1'b0, mx} + {1'b0, mn};
  assign swing = mx - mn;
  pulse_edge_cnt #(.CNT_W(CNT_W)) u_edge (
    .clk(ad_clk),
    .rst_n(rst_n),
    .pulse(ad_pulse),
    .clr(state == IDLE && start),
    .en(state == GATE),
    .cnt(acc)
  );
  always_ff @(posedge ad_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gate_cnt <= '0;
      mn <= '0;
      mx <= '0;
      trig_level <= TRIG_INIT;
      busy <= 1'b0;
      done <= 1'b0;
      edge_cnt <= '0;
      data_max <= '0;
      data_min <= '0;
      no_signal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= GATE;
          busy <= 1'b1;
          gate_cnt <= '0;
          mn <= '1;
          mx <= '0;
        end
        GATE: begin
          mn <= ad_data < mn ? ad_data : mn;
          mx <= ad_data > mx ? ad_data : mx;
          gate_cnt <= gate_cnt + 1'b1;
          if (gate_cnt == LAST) state <= UPDATE;
        end
        default: begin
          if (int'(swing) >= MIN_SWING) trig_level <= sum[DATA_W:1];
          no_signal <= int'(swing) < MIN_SWING;
          edge_cnt <= acc;
          data_max <= mx;
          data_min <= mn;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_meas_ctrl.sv
// tb_pulse_meas_ctrl: directed and randomized checks against a gate-level
// behavioural model (sample queue + arithmetic over each finished gate).
module tb_pulse_meas_ctrl;
  localparam int G = 100;
  logic clk = 1'b0;
  logic rst_n, start, ad_pulse;
  logic [7:0] ad_data;
  logic [7:0] trig_level, data_max, data_min;
  logic busy, done, no_signal;
  logic [31:0] edge_cnt;
  logic [7:0] trig4, max4, min4;
  logic busy4, done4, ns4;
  logic [3:0] cnt4;
  int total = 0, bad = 0;
  int cyc = 0, busy_n = 0, done_n = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  pulse_meas_ctrl #(.CNT_W(32), .GATE_CYCLES(G)) u (
    .ad_clk(clk), .rst_n(rst_n), .start(start), .ad_data(ad_data), .ad_pulse(ad_pulse),
    .trig_level(trig_level), .busy(busy), .done(done), .edge_cnt(edge_cnt),
    .data_max(data_max), .data_min(data_min), .no_signal(no_signal)
  );
  pulse_meas_ctrl #(.CNT_W(4), .GATE_CYCLES(G)) u4 (
    .ad_clk(clk), .rst_n(rst_n), .start(start), .ad_data(ad_data), .ad_pulse(ad_pulse),
    .trig_level(trig4), .busy(busy4), .done(done4), .edge_cnt(cnt4),
    .data_max(max4), .data_min(min4), .no_signal(ns4)
  );
  // model: collects one gate's samples, then derives results arithmetically
  bit act = 0, prev = 0;
  int ph, raw;
  logic [7:0] q[$];
  int e_trig = 128, e_busy = 0, e_done = 0, e_cnt = 0, e_cnt4 = 0, e_max = 0, e_min = 0, e_ns = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      act = 0; prev = 0; e_trig = 128; e_busy = 0; e_done = 0;
      e_cnt = 0; e_cnt4 = 0; e_max = 0; e_min = 0; e_ns = 0;
    end else begin
      e_done = 0;
      if (act && ph < G) begin
        q.push_back(ad_data);
        if (ad_pulse && !prev) raw++;
        ph++;
      end else if (act) begin
        e_min = 255; e_max = 0;
        foreach (q[i]) begin
          if (q[i] < e_min) e_min = q[i];
          if (q[i] > e_max) e_max = q[i];
        end
        e_ns = (e_max - e_min) < 8;
        if (!e_ns) e_trig = (e_max + e_min) / 2;
        e_cnt = raw;
        e_cnt4 = raw > 15 ? 15 : raw;
        e_done = 1; e_busy = 0; act = 0;
      end else if (start) begin
        act = 1; ph = 0; raw = 0; q.delete(); e_busy = 1;
      end
      prev = ad_pulse;
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("trig", 32'(trig_level), e_trig);
      chk("busy", 32'(busy), e_busy);
      chk("done", 32'(done), e_done);
      chk("edge_cnt", edge_cnt, e_cnt);
      chk("max", 32'(data_max), e_max);
      chk("min", 32'(data_min), e_min);
      chk("no_signal", 32'(no_signal), e_ns);
      chk("cnt4", 32'(cnt4), e_cnt4);
    end
    busy_n += int'(busy);
    done_n += int'(done);
  end
  function automatic logic [7:0] gdata(input int mode, input int k);
    case (mode)
      0: return 8'(k);
      1: return 8'(40 + (k * 160) / 99);
      2: return k == 0 ? 8'd0 : k == 1 ? 8'd255 : 8'd128;
      3: return 8'd100;
      default: return 8'd50;
    endcase
  endfunction
  function automatic logic gpulse(input int mode, input int k);
    if (mode == 0) return (k % 10) >= 5;
    if (mode == 4) return k < 60 && (k % 2) == 1;
    return 1'b0;
  endfunction
  task automatic run_gate(input int mode, input bit mid_start, input bit mid_rst, output int lat);
    int s_cyc;
    bit seen = 0;
    busy_n = 0; done_n = 0; lat = -1;
    start = 1;
    @(posedge clk); #1;
    s_cyc = cyc; start = 0;
    for (int k = 0; k < G; k++) begin
      ad_data = gdata(mode, k);
      ad_pulse = gpulse(mode, k);
      start = mid_start && k == 50;
      rst_n = !(mid_rst && k == 50);
      @(posedge clk); #1;
    end
    start = 0; rst_n = 1; ad_pulse = 0;
    if (!mid_rst) begin
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; lat = cyc - s_cyc + 1; end
      end
      chk("done_seen", 32'(seen), 1);
    end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int lat;
    rst_n = 0; start = 0; ad_pulse = 0; ad_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_trig", 32'(trig_level), 128);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ns", 32'(no_signal), 0);
    chk("rst_cnt", edge_cnt, 0);
    chk_en = 1;
    #1 rst_n = 1;
    @(posedge clk); #1;
    run_gate(0, 0, 0, lat);
    chk("sq_latency", 32'(lat), 102);
    chk("sq_busy_cycles", 32'(busy_n), 101);
    chk("sq_edges", edge_cnt, 10);
    chk("sq_trig", 32'(trig_level), 49);
    run_gate(1, 0, 0, lat);
    chk("ramp_min", 32'(data_min), 40);
    chk("ramp_max", 32'(data_max), 200);
    chk("ramp_trig", 32'(trig_level), 120);
    chk("ramp_ns", 32'(no_signal), 0);
    run_gate(2, 0, 0, lat);
    chk("full_trig", 32'(trig_level), 127);
    run_gate(3, 0, 0, lat);
    chk("const_ns", 32'(no_signal), 1);
    chk("const_trig", 32'(trig_level), 127);
    chk("const_min", 32'(data_min), 100);
    chk("const_max", 32'(data_max), 100);
    run_gate(4, 0, 0, lat);
    chk("sat_cnt32", edge_cnt, 30);
    chk("sat_cnt4", 32'(cnt4), 15);
    run_gate(1, 1, 0, lat);
    chk("mid_start_dones", 32'(done_n), 1);
    chk("mid_start_trig", 32'(trig_level), 120);
    run_gate(1, 0, 1, lat);
    chk("mid_rst_dones", 32'(done_n), 0);
    chk("mid_rst_trig", 32'(trig_level), 128);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", edge_cnt, 0);
    chk("mid_rst_max", 32'(data_max), 0);
    begin
      int base = 0, span = 255;
      for (int n = 0; n < 4000; n++) begin
        if (n % 150 == 0) begin
          case ($urandom_range(0, 3))
            0: span = 3;
            1: span = 7;
            2: span = 8;
            default: span = 255;
          endcase
          base = $urandom_range(0, 255 - span);
        end
        ad_data = 8'(base + $urandom_range(0, span));
        if ($urandom_range(0, 3) == 0) ad_pulse = !ad_pulse;
        start = $urandom_range(0, 15) == 0;
        rst_n = $urandom_range(0, 499) != 0;
        @(posedge clk); #1;
      end
    end
    start = 0; rst_n = 1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
